// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit add/subtract on one full-adder slice, LSB first, with a registered carry.
// Latency: start edge E0 -> busy for WIDTH cycles -> sum/cout/ovf and one-cycle done after E0+WIDTH.
// Backpressure: none queued; start is sampled only in IDLE and ignored while busy or done.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    // Holds the WIDTH-1 low result bits; the MSB comes straight from the slice.
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [IDXW-1:0]  bit_idx_q, bit_idx_d;
    logic             carry_q, carry_d;
    logic             msb_cin_q, msb_cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_c;
    logic last_bit;
    logic pre_msb_bit;

    // Shared single-bit full adder slice.
    assign fa_s = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign fa_c = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    assign last_bit    = (bit_idx_q == IDXW'(WIDTH - 1));
    assign pre_msb_bit = (bit_idx_q == IDXW'(WIDTH - 2));

    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        bit_idx_d = bit_idx_q;
        carry_d   = carry_q;
        msb_cin_d = msb_cin_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opa_d     = a;
                    opb_d     = sub ? ~b : b;
                    carry_d   = sub ? 1'b1 : cin;
                    bit_idx_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                opa_d     = opa_q >> 1;
                opb_d     = opb_q >> 1;
                acc_d     = (WIDTH-1)'({fa_s, acc_q} >> 1);
                carry_d   = fa_c;
                bit_idx_d = bit_idx_q + IDXW'(1);
                if (pre_msb_bit) begin
                    msb_cin_d = fa_c;
                end
                if (last_bit) begin
                    sum_d   = {fa_s, acc_q};
                    cout_d  = fa_c;
                    ovf_d   = msb_cin_q ^ fa_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            bit_idx_q <= '0;
            carry_q   <= 1'b0;
            msb_cin_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            bit_idx_q <= bit_idx_d;
            carry_q   <= carry_d;
            msb_cin_q <= msb_cin_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    // Status decoded directly from the state register, so it is glitch-free.
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
